// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: size defaults,
// the latency-width helper, the latency codes decode emits, and the
// control-output encoding.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_MAX_LAT    = 4;

  // Width of a countdown counter able to hold 0..maxLat.
  function automatic int latWidth(input int maxLat);
    return $clog2(maxLat + 1);
  endfunction

  // Producer latency codes, shared with decode.
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = DEF_MAX_LAT;

  // Which of the four fixed-priority control responses applies this cycle.
  typedef enum logic [1:0] {
    CTL_NORMAL = 2'd0,
    CTL_STALL  = 2'd1,
    CTL_BRANCH = 2'd2,
    CTL_FLUSH  = 2'd3
  } ctlMode_e;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifFlush;
    logic bubble;
  } hazCtl_t;

  // Map a control mode to the pipeline-control signal set.
  function automatic hazCtl_t ctlFor(input ctlMode_e mode);
    hazCtl_t ctl;
    unique case (mode)
      CTL_FLUSH:  ctl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifFlush: 1'b1, bubble: 1'b1};
      CTL_BRANCH: ctl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifFlush: 1'b1, bubble: 1'b0};
      CTL_STALL:  ctl = '{pcWrite: 1'b0, ifIdWrite: 1'b0, ifFlush: 1'b0, bubble: 1'b1};
      default:    ctl = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifFlush: 1'b0, bubble: 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the register's pending
// result becomes forwardable. Load saturates at MAX_LAT, clear wins over
// everything, otherwise a nonzero count decrements once per cycle.
module hazard_sb_entry #(
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = 3
) (
  input  logic             inClk,
  input  logic             inRst_n,
  input  logic             inClear,
  input  logic             inLoad,
  input  logic [LAT_W-1:0] inLoadLat,
  output logic [LAT_W-1:0] outCnt
);

  localparam logic [LAT_W-1:0] LAT_CAP = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] satLat;

  // Clamp an oversized requested latency to the largest trackable value.
  assign satLat = (inLoadLat > LAT_CAP) ? LAT_CAP : inLoadLat;

  // Countdown register: clear, then newest-producer load, then decrement.
  // NOTE: the counters are reset, unlike a RAM array, because a stale
  // nonzero count left over from before reset would stall the pipeline.
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      cnt <= '0;
    end else if (inClear) begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      cnt <= '0;
    end else if (inLoad) begin
      cnt <= satLat;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign outCnt = cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection and stall/flush control using a per-register
// countdown scoreboard, so producers of any latency up to MAX_LAT are
// tracked. Outputs are purely combinational from the scoreboard and inputs.
// Optional macro HAZARD_PERF_EN builds stall/branch-flush cycle counters;
// without it the count ports are tied to zero and no counter flops exist.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int  MAX_LAT    = DEF_MAX_LAT,
  localparam int NREG       = 2 ** REG_ADDR_W,
  localparam int LAT_W      = latWidth(MAX_LAT)
) (
  input  logic                  inClk,
  input  logic                  inRst_n,
  input  logic                  inIssueValid,
  input  logic                  inIssueWrite,
  input  logic [REG_ADDR_W-1:0] inIssueRd,
  input  logic [LAT_W-1:0]      inIssueLat,
  input  logic [REG_ADDR_W-1:0] inIF_IDRs,
  input  logic [REG_ADDR_W-1:0] inIF_IDRt,
  input  logic                  inUsesRs,
  input  logic                  inUsesRt,
  input  logic                  inPCSrc,
  input  logic                  inFlushAll,
  output logic                  outPCWrite,
  output logic                  outIF_IDWrite,
  output logic                  outIF_Flush,
  output logic                  outBubble,
  output logic [31:0]           outStallCount,
  output logic [31:0]           outFlushCount
);

  logic [LAT_W-1:0] cnt [NREG];
  logic             rsBusy;
  logic             rtBusy;
  logic             haz;
  logic             issue;
  logic             track;
  ctlMode_e         mode;
  hazCtl_t          ctl;

  // r0 is hardwired, so it can never be a pending producer.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : gEntry
    hazard_sb_entry #(
      .MAX_LAT(MAX_LAT),
      .LAT_W  (LAT_W)
    ) uEntry (
      .inClk    (inClk),
      .inRst_n  (inRst_n),
      .inClear  (inFlushAll),
      .inLoad   (track && (inIssueRd == REG_ADDR_W'(r))),
      .inLoadLat(inIssueLat),
      .outCnt   (cnt[r])
    );
  end

  assign rsBusy = inUsesRs && (inIF_IDRs != '0) && (cnt[inIF_IDRs] != '0);
  assign rtBusy = inUsesRt && (inIF_IDRt != '0) && (cnt[inIF_IDRt] != '0);
  assign haz    = rsBusy || rtBusy;

  // A taken branch issues even when its own operands look hazardous.
  assign issue = inIssueValid && !inFlushAll && (inPCSrc || !haz);
  assign track = issue && inIssueWrite && (inIssueRd != '0) && (inIssueLat != '0);

  // Fixed-priority selection of the pipeline control response.
  // NOTE: mode gets a default first so every path assigns it; no latch.
  always_comb begin
    mode = CTL_NORMAL;
    if (inFlushAll) begin
      mode = CTL_FLUSH;
    end else if (inPCSrc) begin
      mode = CTL_BRANCH;
    end else if (haz) begin
      mode = CTL_STALL;
    end
  end

  assign ctl           = ctlFor(mode);
  assign outPCWrite    = ctl.pcWrite;
  assign outIF_IDWrite = ctl.ifIdWrite;
  assign outIF_Flush   = ctl.ifFlush;
  assign outBubble     = ctl.bubble;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;

  // Count stall cycles and branch-flush cycles; both wrap modulo 2^32.
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (mode == CTL_STALL) begin
        stallCount <= stallCount + 32'd1;
      end
      if (mode == CTL_BRANCH) begin
        flushCount <= flushCount + 32'd1;
      end
    end
  end

  assign outStallCount = stallCount;
  assign outFlushCount = flushCount;
`else
  assign outStallCount = '0;
  assign outFlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The reference model tracks,
// per register, the first cycle at which its pending result is readable,
// and derives the expected control response from that.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_ADDR_W = DEF_REG_ADDR_W;
  localparam int MAX_LAT    = DEF_MAX_LAT;
  localparam int NREG       = 2 ** REG_ADDR_W;
  localparam int LAT_W      = latWidth(MAX_LAT);
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  inClk = 1'b0;
  logic                  inRst_n = 1'b0;
  logic                  inIssueValid, inIssueWrite, inUsesRs, inUsesRt;
  logic                  inPCSrc, inFlushAll;
  logic [REG_ADDR_W-1:0] inIssueRd, inIF_IDRs, inIF_IDRt;
  logic [LAT_W-1:0]      inIssueLat;
  logic                  outPCWrite, outIF_IDWrite, outIF_Flush, outBubble;
  logic [31:0]           outStallCount, outFlushCount;
  logic [3:0]            obsCtl;

  int          checks = 0;
  int          fails  = 0;
  longint      cyc    = 0;
  longint      readyAt [NREG];
  logic [31:0] expStall = '0;
  logic [31:0] expFlush = '0;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .MAX_LAT(MAX_LAT)) dut (
    .inClk(inClk), .inRst_n(inRst_n),
    .inIssueValid(inIssueValid), .inIssueWrite(inIssueWrite),
    .inIssueRd(inIssueRd), .inIssueLat(inIssueLat),
    .inIF_IDRs(inIF_IDRs), .inIF_IDRt(inIF_IDRt),
    .inUsesRs(inUsesRs), .inUsesRt(inUsesRt),
    .inPCSrc(inPCSrc), .inFlushAll(inFlushAll),
    .outPCWrite(outPCWrite), .outIF_IDWrite(outIF_IDWrite),
    .outIF_Flush(outIF_Flush), .outBubble(outBubble),
    .outStallCount(outStallCount), .outFlushCount(outFlushCount)
  );

  assign obsCtl = {outPCWrite, outIF_IDWrite, outIF_Flush, outBubble};

  always #5 inClk = ~inClk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expired", cyc);
    $fatal(1);
  end

  function automatic bit busy(input int r);
    return (r != 0) && (cyc < readyAt[r]);
  endfunction

  function automatic bit expHaz();
    return (inUsesRs && busy(int'(inIF_IDRs))) || (inUsesRt && busy(int'(inIF_IDRt)));
  endfunction

  function automatic logic [3:0] expCtl();
    if (inFlushAll) return 4'b1111;
    if (inPCSrc)    return 4'b1110;
    if (expHaz())   return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic setIn(input int v, input int w, input int rd, input int lat,
                       input int rs, input int rt, input int ur, input int ut,
                       input int pc, input int fa);
    inIssueValid = v[0];
    inIssueWrite = w[0];
    inIssueRd    = REG_ADDR_W'(rd);
    inIssueLat   = LAT_W'(lat);
    inIF_IDRs    = REG_ADDR_W'(rs);
    inIF_IDRt    = REG_ADDR_W'(rt);
    inUsesRs     = ur[0];
    inUsesRt     = ut[0];
    inPCSrc      = pc[0];
    inFlushAll   = fa[0];
    #1;
  endtask

  // Advance one clock and move the model forward with the inputs just applied.
  task automatic tick();
    bit h, iss;
    int lat;
    @(posedge inClk);
    h   = expHaz();
    iss = inIssueValid && !inFlushAll && (inPCSrc || !h);
    if (PERF) begin
      if (h && !inPCSrc && !inFlushAll) expStall = expStall + 32'd1;
      if (inPCSrc && !inFlushAll)       expFlush = expFlush + 32'd1;
    end
    if (inFlushAll) begin
      foreach (readyAt[r]) readyAt[r] = cyc + 1;
    end else if (iss && inIssueWrite && inIssueRd != 0 && inIssueLat != 0) begin
      lat = (int'(inIssueLat) > MAX_LAT) ? MAX_LAT : int'(inIssueLat);
      readyAt[inIssueRd] = cyc + lat + 1;
    end
    cyc++;
    @(negedge inClk);
  endtask

  task automatic test_reset();
    foreach (readyAt[r]) readyAt[r] = 0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsCtl !== 4'b1100) begin
      fails++; $display("FAIL reset_ctl got=%b want=%b", obsCtl, 4'b1100);
    end
    checks++;
    if (outStallCount !== 32'd0 || outFlushCount !== 32'd0) begin
      fails++; $display("FAIL reset_counts got=%0d/%0d want=0/0", outStallCount, outFlushCount);
    end
    @(negedge inClk);
    inRst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    bit done;
    setIn(1, 1, 5, LAT_LOAD, 2, 3, 1, 1, 0, 0);
    checks++;
    if (obsCtl !== expCtl()) begin
      fails++; $display("FAIL load_use_issue cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      setIn(1, 1, 6, LAT_ALU, 5, 1, 1, 1, 0, 0);
      checks++;
      if (obsCtl !== expCtl()) begin
        fails++; $display("FAIL load_use_ctl cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
      end
      done = (outBubble !== 1'b1);
      tick();
      if (done) break;
      stalls++;
    end
    checks++;
    if (stalls != 1) begin
      fails++; $display("FAIL load_use_stalls got=%0d want=1", stalls);
    end
  endtask

  task automatic test_mul_rt();
    int stalls;
    bit done;
    for (int pass = 0; pass < 2; pass++) begin
      setIn(1, 1, 7, LAT_MUL, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obsCtl !== expCtl()) begin
        fails++; $display("FAIL mul_issue cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
      end
      tick();
      stalls = 0;
      for (int k = 0; k < 10; k++) begin
        setIn(1, 1, 11, LAT_ALU, 1, 7, 1, (pass == 0) ? 1 : 0, 0, 0);
        checks++;
        if (obsCtl !== expCtl()) begin
          fails++; $display("FAIL mul_rt_ctl cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
        end
        done = (outBubble !== 1'b1);
        tick();
        if (done) break;
        stalls++;
      end
      checks++;
      if (stalls != ((pass == 0) ? 3 : 0)) begin
        fails++; $display("FAIL mul_rt_stalls pass=%0d got=%0d want=%0d", pass, stalls, (pass == 0) ? 3 : 0);
      end
      // Let any remaining r7 countdown drain before the next pass.
      for (int k = 0; k < 4; k++) begin
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
      end
    end
  endtask

  task automatic test_r0();
    setIn(1, 1, 0, LAT_DIV, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(1, 1, 12, LAT_ALU, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obsCtl !== 4'b1100) begin
      fails++; $display("FAIL r0_no_stall got=%b want=%b", obsCtl, 4'b1100);
    end
    tick();
  endtask

  task automatic test_branch_in_stall();
    logic [31:0] s0, f0;
    setIn(1, 1, 5, 3, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(1, 1, 6, LAT_ALU, 5, 0, 1, 0, 0, 0);
    checks++;
    if (obsCtl !== 4'b0001) begin
      fails++; $display("FAIL branch_pre_stall got=%b want=%b", obsCtl, 4'b0001);
    end
    tick();
    s0 = expStall;
    f0 = expFlush;
    setIn(1, 1, 6, LAT_ALU, 5, 0, 1, 0, 1, 0);
    checks++;
    if (obsCtl !== 4'b1110) begin
      fails++; $display("FAIL branch_ctl got=%b want=%b", obsCtl, 4'b1110);
    end
    tick();
    checks++;
    if (outStallCount !== s0 || outFlushCount !== (PERF ? f0 + 32'd1 : 32'd0)) begin
      fails++; $display("FAIL branch_counts got=%0d/%0d want=%0d/%0d",
                        outStallCount, outFlushCount, s0, PERF ? f0 + 32'd1 : 32'd0);
    end
  endtask

  task automatic test_waw();
    int stalls = 0;
    bit done;
    for (int k = 0; k < 4; k++) begin
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    setIn(1, 1, 8, LAT_MUL, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(1, 1, 8, LAT_LOAD, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsCtl !== expCtl()) begin
      fails++; $display("FAIL waw_reload cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      setIn(1, 0, 0, LAT_ALU, 8, 0, 1, 0, 0, 0);
      checks++;
      if (obsCtl !== expCtl()) begin
        fails++; $display("FAIL waw_ctl cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
      end
      done = (outBubble !== 1'b1);
      tick();
      if (done) break;
      stalls++;
    end
    checks++;
    if (stalls != 1) begin
      fails++; $display("FAIL waw_stalls got=%0d want=1", stalls);
    end
  endtask

  task automatic test_flush_all();
    setIn(1, 1, 9, 3, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(1, 1, 4, 2, 9, 0, 1, 0, 0, 1);
    checks++;
    if (obsCtl !== 4'b1111) begin
      fails++; $display("FAIL flush_all_ctl got=%b want=%b", obsCtl, 4'b1111);
    end
    tick();
    setIn(1, 0, 0, 0, 9, 4, 1, 1, 0, 0);
    checks++;
    if (obsCtl !== 4'b1100) begin
      fails++; $display("FAIL flush_all_cleared got=%b want=%b", obsCtl, 4'b1100);
    end
    tick();
  endtask

  task automatic test_saturate();
    int stalls = 0;
    bit done;
    setIn(1, 1, 10, 7, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 12; k++) begin
      setIn(1, 0, 0, LAT_ALU, 0, 10, 0, 1, 0, 0);
      checks++;
      if (obsCtl !== expCtl()) begin
        fails++; $display("FAIL sat_ctl cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
      end
      done = (outBubble !== 1'b1);
      tick();
      if (done) break;
      stalls++;
    end
    checks++;
    if (stalls != MAX_LAT) begin
      fails++; $display("FAIL sat_stalls got=%0d want=%0d", stalls, MAX_LAT);
    end
  endtask

  task automatic test_reset_mid_stall();
    setIn(1, 1, 5, LAT_DIV, 0, 0, 0, 0, 0, 0);
    tick();
    setIn(1, 1, 6, LAT_ALU, 5, 0, 1, 0, 0, 0);
    checks++;
    if (obsCtl !== 4'b0001) begin
      fails++; $display("FAIL rst_mid_pre got=%b want=%b", obsCtl, 4'b0001);
    end
    inRst_n = 1'b0;
    #1;
    foreach (readyAt[r]) readyAt[r] = 0;
    expStall = '0;
    expFlush = '0;
    checks++;
    if (obsCtl !== 4'b1100) begin
      fails++; $display("FAIL rst_mid_ctl got=%b want=%b", obsCtl, 4'b1100);
    end
    checks++;
    if (outStallCount !== 32'd0 || outFlushCount !== 32'd0) begin
      fails++; $display("FAIL rst_mid_counts got=%0d/%0d want=0/0", outStallCount, outFlushCount);
    end
    #1 inRst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      setIn(($urandom_range(0, 4) != 0) ? 1 : 0, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 29) == 0) ? 1 : 0);
      checks++;
      if (obsCtl !== expCtl()) begin
        fails++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, obsCtl, expCtl());
      end
      tick();
      checks++;
      if (outStallCount !== expStall || outFlushCount !== expFlush) begin
        fails++; $display("FAIL rand_counts cyc=%0d got=%0d/%0d want=%0d/%0d",
                          cyc, outStallCount, outFlushCount, expStall, expFlush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul_rt();
    test_r0();
    test_branch_in_stall();
    test_waw();
    test_flush_all();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
